// File: rtl/pos_sweep_pkg.sv
// Shared types and constants for the product-of-sums truth-table sweep evaluator.
// Holds the FSM state enum, the truth-table size derivation and the widest supported input count.
package pos_sweep_pkg;

    localparam int MAX_N_IN = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_t;

    function automatic int rows_of(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/pos_row_lut.sv
// Combinational truth-table row lookup: selects one maxterm mask bit and inverts it,
// so a set mask bit means the row evaluates to 0.
module pos_row_lut
    import pos_sweep_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int ROWS = rows_of(N_IN)
) (
    input  logic [ROWS-1:0] mask,
    input  logic [N_IN-1:0] sel,
    output logic            r
);

    assign r = ~mask[sel];

endmodule

// File: rtl/pos_sweep_eval.sv
// Product-of-sums function evaluator with direct lookup and an exhaustive row sweep.
// Optional golden-mask comparison is built only when POS_SWEEP_CHECK_EN is defined.
module pos_sweep_eval
    import pos_sweep_pkg::*;
#(
    parameter int  N_IN = 4,
    localparam int ROWS = rows_of(N_IN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [ROWS-1:0] mask_in,
    input  logic            start,
    input  logic            abort,
    input  logic [N_IN-1:0] man_in,
    output logic            man_r,
    output logic [N_IN-1:0] sweep_x,
    output logic            sweep_r,
    output logic            sweep_valid,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   ones_count
`ifdef POS_SWEEP_CHECK_EN
    ,
    input  logic [ROWS-1:0] golden_in,
    output logic [N_IN:0]   mismatch_cnt,
    output logic            pass
`endif
);

    sweep_state_t    state_q, state_d;
    logic [ROWS-1:0] mask_q, mask_d;
    logic [N_IN-1:0] cnt_q, cnt_d;
    logic            last_q, last_d;
    logic [N_IN-1:0] sweep_x_q, sweep_x_d;
    logic            sweep_r_q, sweep_r_d;
    logic            sweep_valid_q, sweep_valid_d;
    logic [N_IN:0]   ones_q, ones_d;
    logic            row_r;
    logic            start_go;
    logic            beat;

    pos_row_lut #(.N_IN(N_IN), .ROWS(ROWS)) u_man_lut (
        .mask (mask_q),
        .sel  (man_in),
        .r    (man_r)
    );

    pos_row_lut #(.N_IN(N_IN), .ROWS(ROWS)) u_sweep_lut (
        .mask (mask_q),
        .sel  (cnt_q),
        .r    (row_r)
    );

    // last_q marks the drain cycle after the final row, so done appears one edge after it
    assign start_go = (state_q != ST_SWEEP) && start;
    assign beat     = (state_q == ST_SWEEP) && !abort && !last_q;

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        sweep_x_d     = sweep_x_q;
        sweep_r_d     = sweep_r_q;
        sweep_valid_d = 1'b0;
        ones_d        = ones_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load) begin
                    mask_d = mask_in;
                end
                if (start) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    ones_d  = '0;
                end
            end
            ST_SWEEP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                end else if (last_q) begin
                    state_d = ST_DONE;
                    last_d  = 1'b0;
                end else begin
                    sweep_valid_d = 1'b1;
                    sweep_x_d     = cnt_q;
                    sweep_r_d     = row_r;
                    ones_d        = ones_q + {{N_IN{1'b0}}, row_r};
                    cnt_d         = cnt_q + N_IN'(1);
                    last_d        = &cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mask_q        <= '0;
            cnt_q         <= '0;
            last_q        <= 1'b0;
            sweep_x_q     <= '0;
            sweep_r_q     <= 1'b0;
            sweep_valid_q <= 1'b0;
            ones_q        <= '0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            sweep_x_q     <= sweep_x_d;
            sweep_r_q     <= sweep_r_d;
            sweep_valid_q <= sweep_valid_d;
            ones_q        <= ones_d;
        end
    end

    assign sweep_x     = sweep_x_q;
    assign sweep_r     = sweep_r_q;
    assign sweep_valid = sweep_valid_q;
    assign busy        = (state_q == ST_SWEEP);
    assign done        = (state_q == ST_DONE);
    assign ones_count  = ones_q;

`ifdef POS_SWEEP_CHECK_EN
    logic [ROWS-1:0] golden_q, golden_d;
    logic [N_IN:0]   mismatch_q, mismatch_d;

    // Golden mask is frozen at start so it may change freely while the sweep runs
    always_comb begin
        golden_d   = golden_q;
        mismatch_d = mismatch_q;
        if (start_go) begin
            golden_d   = golden_in;
            mismatch_d = '0;
        end else if (beat && (row_r != ~golden_q[cnt_q])) begin
            mismatch_d = mismatch_q + {{N_IN{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            golden_q   <= '0;
            mismatch_q <= '0;
        end else begin
            golden_q   <= golden_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch_cnt = mismatch_q;
    assign pass         = done && (mismatch_q == '0);
`endif

endmodule

// File: tb/tb_pos_sweep_eval.sv
// Self-checking bench for pos_sweep_eval (N_IN=4) against a truth-table reference model.
// Define POS_SWEEP_CHECK_EN to also exercise the golden-mask comparison ports.
module tb_pos_sweep_eval;

    localparam int N_IN = 4;
    localparam int ROWS = 16;

    logic            clk;
    logic            rst;
    logic            load;
    logic [ROWS-1:0] mask_in;
    logic            start;
    logic            abort;
    logic [N_IN-1:0] man_in;
    logic            man_r;
    logic [N_IN-1:0] sweep_x;
    logic            sweep_r;
    logic            sweep_valid;
    logic            busy;
    logic            done;
    logic [N_IN:0]   ones_count;
`ifdef POS_SWEEP_CHECK_EN
    logic [ROWS-1:0] golden_in;
    logic [N_IN:0]   mismatch_cnt;
    logic            pass;
`endif

    int tests_run;
    int tests_failed;

    pos_sweep_eval #(.N_IN(N_IN)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .mask_in     (mask_in),
        .start       (start),
        .abort       (abort),
        .man_in      (man_in),
        .man_r       (man_r),
        .sweep_x     (sweep_x),
        .sweep_r     (sweep_r),
        .sweep_valid (sweep_valid),
        .busy        (busy),
        .done        (done),
        .ones_count  (ones_count)
`ifdef POS_SWEEP_CHECK_EN
        ,
        .golden_in    (golden_in),
        .mismatch_cnt (mismatch_cnt),
        .pass         (pass)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a POS function is 0 exactly on rows whose maxterm bit is set
    function automatic logic model_row(input logic [15:0] m, input int x);
        return ((int'(m) >> x) & 1) == 0;
    endfunction

    function automatic int model_ones(input logic [15:0] m, input int upto);
        int n = 0;
        for (int i = 0; i < upto; i++) n += int'(model_row(m, i));
        return n;
    endfunction

    task automatic test_reset();
        logic [15:0] m;
        rst = 1'b1; load = 1'b0; start = 1'b0; abort = 1'b0; mask_in = '0; man_in = '0;
        #12;
        tests_run++;
        if ({busy, done, sweep_valid, sweep_r} !== 4'b0000 || ones_count !== 5'd0 || sweep_x !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b valid=%b r=%b x=%0d ones=%0d, want all 0",
                     busy, done, sweep_valid, sweep_r, sweep_x, ones_count);
        end
        @(negedge clk) rst = 1'b0;
        m = 16'($urandom) | 16'h8001;
        @(posedge clk); #1;
        load = 1'b1; mask_in = m; start = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        tests_run++;
        if ({busy, done, sweep_valid} !== 3'b000 || ones_count !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_midsweep: got busy=%b done=%b valid=%b ones=%0d, want 0 0 0 0",
                     busy, done, sweep_valid, ones_count);
        end
        for (int i = 0; i < ROWS; i++) begin
            man_in = 4'(i);
            #1;
            tests_run++;
            if (man_r !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL reset_man_r row %0d: got %b want 1", i, man_r);
            end
        end
        @(negedge clk) rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_no_done: got done=%b busy=%b want 0 0", done, busy);
            end
        end
    endtask

    task automatic test_full_sweep(input logic [15:0] m);
        int ones = 0;
        logic [3:0] mi;
        load = 1'b1; mask_in = m; start = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; start = 1'b0; mask_in = ~m;
        for (int k = 0; k < ROWS; k++) begin
            @(posedge clk); #1;
            ones += int'(model_row(m, k));
            tests_run++;
            if (sweep_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || sweep_x !== 4'(k) || sweep_r !== model_row(m, k)) begin
                tests_failed++;
                $display("[TB] FAIL sweep_beat %0d mask %h: got valid=%b busy=%b done=%b x=%0d r=%b, want 1 1 0 %0d %b",
                         k, m, sweep_valid, busy, done, sweep_x, sweep_r, k, model_row(m, k));
            end
            mi = 4'($urandom_range(0, ROWS - 1));
            man_in = mi;
            #1;
            tests_run++;
            if (man_r !== model_row(m, int'(mi))) begin
                tests_failed++;
                $display("[TB] FAIL man_r row %0d mask %h: got %b want %b", mi, m, man_r, model_row(m, int'(mi)));
            end
        end
        repeat (3) begin
            @(posedge clk); #1;
            tests_run++;
            if (done !== 1'b1 || busy !== 1'b0 || sweep_valid !== 1'b0 || ones_count !== 5'(ROWS - $countones(m))) begin
                tests_failed++;
                $display("[TB] FAIL sweep_done mask %h: got done=%b busy=%b valid=%b ones=%0d, want 1 0 0 %0d",
                         m, done, busy, sweep_valid, ones_count, ROWS - $countones(m));
            end
        end
    endtask

    task automatic test_known_vector();
        test_full_sweep(16'hE76B);
        tests_run++;
        if (ones_count !== 5'd5) begin
            tests_failed++;
            $display("[TB] FAIL known_vector_ones: got %0d want 5", ones_count);
        end
    endtask

    task automatic test_abort();
        logic [15:0] m = 16'hE76B;
        load = 1'b1; mask_in = m; start = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        tests_run++;
        if (sweep_x !== 4'd6 || sweep_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL abort_beat: got x=%0d valid=%b want 6 1", sweep_x, sweep_valid);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        tests_run++;
        if ({busy, done, sweep_valid} !== 3'b000 || ones_count !== 5'(model_ones(m, 7)) || ones_count !== 5'd2) begin
            tests_failed++;
            $display("[TB] FAIL abort_state: got busy=%b done=%b valid=%b ones=%0d, want 0 0 0 2",
                     busy, done, sweep_valid, ones_count);
        end
        repeat (20) begin
            @(posedge clk); #1;
            tests_run++;
            if (done !== 1'b0 || ones_count !== 5'd2) begin
                tests_failed++;
                $display("[TB] FAIL abort_hold: got done=%b ones=%0d want 0 2", done, ones_count);
            end
        end
    endtask

    task automatic test_ignored_inputs();
        logic [15:0] m = 16'hE76B;
        load = 1'b1; mask_in = m; start = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; start = 1'b0;
        for (int k = 0; k < ROWS; k++) begin
            @(posedge clk); #1;
            load = 1'b0; start = 1'b0;
            tests_run++;
            if (sweep_valid !== 1'b1 || sweep_x !== 4'(k) || sweep_r !== model_row(m, k)) begin
                tests_failed++;
                $display("[TB] FAIL ignored_beat %0d: got valid=%b x=%0d r=%b, want 1 %0d %b",
                         k, sweep_valid, sweep_x, sweep_r, k, model_row(m, k));
            end
            if (k == 3) begin
                load = 1'b1; mask_in = 16'h0000; start = 1'b1;
            end else if (k == 8 || k == 15) begin
                start = 1'b1;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if (done !== 1'b1 || ones_count !== 5'd5) begin
            tests_failed++;
            $display("[TB] FAIL ignored_done: got done=%b ones=%0d want 1 5", done, ones_count);
        end
        for (int i = 0; i < ROWS; i++) begin
            man_in = 4'(i);
            #1;
            tests_run++;
            if (man_r !== model_row(m, i)) begin
                tests_failed++;
                $display("[TB] FAIL ignored_mask row %0d: got %b want %b", i, man_r, model_row(m, i));
            end
        end
    endtask

    task automatic test_load_start();
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL load_start_pre: got done=%b want 1", done);
        end
        test_full_sweep(16'hFFFF);
        tests_run++;
        if (ones_count !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL load_start_ones: got %0d want 0", ones_count);
        end
    endtask

    task automatic test_random_sweeps();
        repeat (6) test_full_sweep(16'($urandom));
    endtask

`ifdef POS_SWEEP_CHECK_EN
    task automatic test_check(input logic [15:0] m, input logic [15:0] g);
        int mis = $countones(m ^ g);
        golden_in = g; load = 1'b1; mask_in = m; start = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; start = 1'b0; golden_in = 16'($urandom);
        repeat (ROWS + 1) @(posedge clk);
        #1;
        tests_run++;
        if (done !== 1'b1 || mismatch_cnt !== 5'(mis) || pass !== (mis == 0)) begin
            tests_failed++;
            $display("[TB] FAIL check mask %h golden %h: got done=%b mis=%0d pass=%b, want 1 %0d %b",
                     m, g, done, mismatch_cnt, pass, mis, mis == 0);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
`ifdef POS_SWEEP_CHECK_EN
        golden_in = '0;
`endif
        test_reset();
        test_known_vector();
        test_abort();
        test_ignored_inputs();
        test_load_start();
        test_random_sweeps();
`ifdef POS_SWEEP_CHECK_EN
        test_check(16'hE76B, 16'hE76B);
        test_check(16'hE76B, 16'hE76A);
        test_check(16'($urandom), 16'($urandom));
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
